// File: rtl/klingon_scan_ctrl.sv
// Four-digit multiplexed display scanner sharing one Klingon digit decoder.
// New values are staged through a valid/ready port and committed per frame.
module klingon_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter bit LZB      = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  dec_in,
    input  logic [6:0]  dec_out,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pend_q, pend_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          fd_q, fd_d;

    logic       tick;
    logic       wrap;
    logic [3:0] nib;
    logic       upper_zero;
    logic       blank;

    always_comb begin
        tick = (cnt_q == CNT_MAX);
        wrap = tick && (ptr_q == 2'd3);
        nib  = disp_q[{ptr_q, 2'b00} +: 4];

        // current nibble and every more significant one are zero
        case (ptr_q)
            2'd0:    upper_zero = (disp_q == 16'd0);
            2'd1:    upper_zero = (disp_q[15:4] == 12'd0);
            2'd2:    upper_zero = (disp_q[15:8] == 8'd0);
            default: upper_zero = (disp_q[15:12] == 4'd0);
        endcase

        blank = (nib > 4'd9) || (LZB && (ptr_q != 2'd0) && upper_zero);
    end

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        ptr_d    = tick ? ptr_q + 2'd1 : ptr_q;
        disp_d   = disp_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        fd_d     = wrap;

        // accept needs !pend, commit needs pend: never both at once
        if (load_valid && !pend_q) begin
            shadow_d = load_data;
            pend_d   = 1'b1;
        end else if (wrap && pend_q) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
        end

        if (blank) begin
            seg_d = 7'b0000000;
            an_d  = 4'b1111;
        end else begin
            seg_d = dec_out;
            an_d  = ~(4'b0001 << ptr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            ptr_q    <= 2'd0;
            disp_q   <= 16'd0;
            shadow_q <= 16'd0;
            pend_q   <= 1'b0;
            seg_q    <= 7'd0;
            an_q     <= 4'b1111;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fd_q     <= fd_d;
        end
    end

    assign load_ready = !pend_q;
    assign dec_in     = nib;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_klingon_scan_ctrl.sv
// Bench for klingon_scan_ctrl: two instances (LZB off/on) in lockstep,
// a reset/scan vector table, directed corner sequences and random loads.
module tb_klingon_scan_ctrl;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lv = 1'b0;
    logic [15:0] ld = 16'd0;

    logic       rdy0, rdy1, fd0, fd1;
    logic [3:0] din0, din1, an0, an1;
    logic [6:0] dout0, dout1, seg0, seg1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [6:0] kl(input logic [3:0] d);
        case (d)
            4'd0: return 7'h5A;
            4'd1: return 7'h13;
            4'd2: return 7'h2C;
            4'd3: return 7'h47;
            4'd4: return 7'h71;
            4'd5: return 7'h0E;
            4'd6: return 7'h39;
            4'd7: return 7'h66;
            4'd8: return 7'h1D;
            4'd9: return 7'h52;
            default: return 7'h7F;
        endcase
    endfunction

    assign dout0 = kl(din0);
    assign dout1 = kl(din1);

    klingon_scan_ctrl #(.SCAN_DIV(SD), .LZB(1'b0)) u0 (
        .clk(clk), .reset(rst), .load_valid(lv), .load_data(ld),
        .load_ready(rdy0), .dec_in(din0), .dec_out(dout0),
        .seg(seg0), .an(an0), .frame_done(fd0)
    );

    klingon_scan_ctrl #(.SCAN_DIV(SD), .LZB(1'b1)) u1 (
        .clk(clk), .reset(rst), .load_valid(lv), .load_data(ld),
        .load_ready(rdy1), .dec_in(din1), .dec_out(dout1),
        .seg(seg1), .an(an1), .frame_done(fd1)
    );

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: time since reset release decides slot and frame
    int          m_n;
    logic [15:0] m_disp, m_shadow;
    bit          m_pend;
    logic [6:0]  e_seg [2];
    logic [3:0]  e_an  [2];
    bit          e_fd;

    function automatic logic [3:0] nib_of(input logic [15:0] v, input int p);
        return 4'((v >> (4 * p)) & 16'hF);
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_disp = 16'd0;
        m_shadow = 16'd0;
        m_pend = 1'b0;
        e_fd = 1'b0;
        for (int l = 0; l < 2; l++) begin
            e_seg[l] = 7'd0;
            e_an[l] = 4'hF;
        end
    endtask

    task automatic model_edge();
        int p;
        bit wr;
        logic [3:0] nb;
        bit bl;
        p = (m_n / SD) % 4;
        wr = ((m_n % (4 * SD)) == 4 * SD - 1);
        nb = nib_of(m_disp, p);
        for (int l = 0; l < 2; l++) begin
            bl = (nb > 4'd9) || (l == 1 && p != 0 && (m_disp >> (4 * p)) == 0);
            e_seg[l] = bl ? 7'd0 : kl(nb);
            e_an[l] = bl ? 4'hF : 4'(~(1 << p));
        end
        e_fd = wr;
        if (lv && !m_pend) begin
            m_shadow = ld;
            m_pend = 1'b1;
        end else if (wr && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        m_n++;
    endtask

    task automatic model_check();
        logic [3:0] e_din;
        e_din = nib_of(m_disp, (m_n / SD) % 4);
        chk("seg0", seg0, e_seg[0]);
        chk("an0", an0, e_an[0]);
        chk("seg1", seg1, e_seg[1]);
        chk("an1", an1, e_an[1]);
        chk("fd0", fd0, e_fd);
        chk("fd1", fd1, e_fd);
        chk("rdy0", rdy0, !m_pend);
        chk("rdy1", rdy1, !m_pend);
        chk("din0", din0, e_din);
        chk("din1", din1, e_din);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    task automatic wait_fd(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = fd0;
        end
        chk("fd_timeout", seen, 1'b1);
    endtask

    typedef struct {
        logic        lv;
        logic [15:0] ld;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fd;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{1'b0, 16'h0, 4'b1111, 7'h00, 1'b0};
        tbl[1]  = '{1'b0, 16'h0, 4'b1110, 7'h5A, 1'b0};
        tbl[2]  = '{1'b0, 16'h0, 4'b1110, 7'h5A, 1'b0};
        tbl[3]  = '{1'b0, 16'h0, 4'b1110, 7'h5A, 1'b0};
        tbl[4]  = '{1'b0, 16'h0, 4'b1110, 7'h5A, 1'b0};
        tbl[5]  = '{1'b0, 16'h0, 4'b1101, 7'h5A, 1'b0};
        tbl[6]  = '{1'b0, 16'h0, 4'b1101, 7'h5A, 1'b0};
        tbl[7]  = '{1'b0, 16'h0, 4'b1101, 7'h5A, 1'b0};
        tbl[8]  = '{1'b0, 16'h0, 4'b1101, 7'h5A, 1'b0};
        tbl[9]  = '{1'b0, 16'h0, 4'b1011, 7'h5A, 1'b0};
        tbl[10] = '{1'b0, 16'h0, 4'b1011, 7'h5A, 1'b0};
        tbl[11] = '{1'b0, 16'h0, 4'b1011, 7'h5A, 1'b0};
        tbl[12] = '{1'b0, 16'h0, 4'b1011, 7'h5A, 1'b0};
        tbl[13] = '{1'b0, 16'h0, 4'b0111, 7'h5A, 1'b0};
        tbl[14] = '{1'b0, 16'h0, 4'b0111, 7'h5A, 1'b0};
        tbl[15] = '{1'b0, 16'h0, 4'b0111, 7'h5A, 1'b0};
        tbl[16] = '{1'b0, 16'h0, 4'b0111, 7'h5A, 1'b1};

        // reset state
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_seg", seg0, 7'd0);
        chk("rst_an", an0, 4'hF);
        chk("rst_fd", fd0, 1'b0);
        chk("rst_rdy", rdy0, 1'b1);
        chk("rst_an1", an1, 4'hF);
        rst = 1'b0;

        // scan sequence after release
        for (int k = 0; k < 17; k++) begin
            lv = tbl[k].lv;
            ld = tbl[k].ld;
            if (k > 0) step();
            chk($sformatf("tbl_an[%0d]", k), an0, tbl[k].an);
            chk($sformatf("tbl_seg[%0d]", k), seg0, tbl[k].seg);
            chk($sformatf("tbl_fd[%0d]", k), fd0, tbl[k].fd);
            chk($sformatf("tbl_rdy[%0d]", k), rdy0, 1'b1);
        end

        // load commit mid-frame
        repeat (5) step();
        lv = 1'b1;
        ld = 16'h1234;
        step();
        lv = 1'b0;
        chk("lc_rdy_low", rdy0, 1'b0);
        chk("lc_disp_old", din0, 4'h0);
        wait_fd(40);
        chk("lc_rdy_back", rdy0, 1'b1);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("lc_din_slot%0d", s), din0, 4'(4 - s));
            repeat (SD) step();
        end

        // back-to-back loads
        lv = 1'b1;
        ld = 16'h0005;
        step();
        ld = 16'h0009;
        wait_fd(40);
        chk("bb_din5", din0, 4'h5);
        chk("bb_rdy_at_commit", rdy0, 1'b1);
        step();
        lv = 1'b0;
        chk("bb_second_acc", rdy0, 1'b0);
        chk("bb_seg5", seg0, kl(4'h5));
        wait_fd(40);
        chk("bb_din9", din0, 4'h9);
        step();
        chk("bb_seg9", seg0, kl(4'h9));

        // blanking with and without leading-zero suppression
        lv = 1'b1;
        ld = 16'h00A7;
        step();
        lv = 1'b0;
        wait_fd(40);
        step();
        chk("bl_s0_seg0", seg0, kl(4'h7));
        chk("bl_s0_seg1", seg1, kl(4'h7));
        chk("bl_s0_an1", an1, 4'b1110);
        repeat (SD) step();
        chk("bl_s1_an0", an0, 4'hF);
        chk("bl_s1_seg0", seg0, 7'd0);
        chk("bl_s1_an1", an1, 4'hF);
        repeat (SD) step();
        chk("bl_s2_an0", an0, 4'b1011);
        chk("bl_s2_seg0", seg0, kl(4'h0));
        chk("bl_s2_an1", an1, 4'hF);
        repeat (SD) step();
        chk("bl_s3_an0", an0, 4'b0111);
        chk("bl_s3_an1", an1, 4'hF);
        chk("bl_s3_seg1", seg1, 7'd0);

        // random loads against the model
        for (int i = 0; i < 400; i++) begin
            lv = ($urandom_range(0, 3) == 0);
            ld = 16'($urandom);
            if ($urandom_range(0, 1) == 1) ld[15:8] = 8'd0;
            if ($urandom_range(0, 2) == 0) ld = ld & 16'h7777;
            step();
        end

        // reset with a load pending and ptr at slot 2
        lv = 1'b0;
        wait_fd(40);
        lv = 1'b1;
        ld = 16'h4321;
        step();
        lv = 1'b0;
        repeat (2 * SD) step();
        chk("mr_pending", rdy0, 1'b0);
        chk("mr_slot2", an0, 4'b1011);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_an", an0, 4'hF);
        chk("mr_seg", seg0, 7'd0);
        chk("mr_rdy", rdy0, 1'b1);
        chk("mr_fd", fd0, 1'b0);
        chk("mr_an1", an1, 4'hF);
        model_reset();
        @(negedge clk);
        model_check();
        rst = 1'b0;
        for (int i = 0; i < 5 * 4 * SD; i++) begin
            step();
            if (i % SD == 0) chk("mr_no_stale", din0, 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
